// File: rtl/regfile_pkg.sv
// Shared constants for the register-file write-back path: data/address widths
// and the fixed requester slots on the single write port.
package regfile_pkg;
    localparam int XLEN    = 32;
    localparam int AW      = 5;
    localparam int NREG    = 1 << AW;
    localparam int REQ_ALU = 0;
    localparam int REQ_LSU = 1;
    localparam int REQ_MDU = 2;
    localparam int NUM_REQ = 3;
endpackage

// File: rtl/regfile_wb_sched_rr_arbiter.sv
// Round-robin arbiter: one-hot grant to the first requester after the last winner.
// The pointer only moves when the caller reports the grant was consumed.
module rr_arbiter #(
    parameter int N = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] req,
    input  logic         advance,
    output logic [N-1:0] gnt
);
    localparam int PW = (N > 1) ? $clog2(N) : 1;

    logic [PW-1:0] r_ptr;
    logic [PW-1:0] w_idx;

    always_comb begin : p_search
        int   c;
        logic found;
        gnt   = '0;
        w_idx = r_ptr;
        found = 1'b0;
        c     = 0;
        for (int k = 1; k <= N; k++) begin
            c = int'(r_ptr) + k;
            if (c >= N) c = c - N;
            if (!found && req[c]) begin
                gnt[c] = 1'b1;
                w_idx  = PW'(c);
                found  = 1'b1;
            end
        end
    end

    // Reset to the last slot so requester 0 is first in line.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ptr <= PW'(N - 1);
        end else if (advance && (|req)) begin
            r_ptr <= w_idx;
        end
    end
endmodule

// File: rtl/regfile_wb_sched.sv
// Write-back scheduler for the 32x32 register file: arbitrates the single write
// port among execution units and keeps a busy scoreboard that stalls RAW/WAW issue.
module regfile_wb_sched #(
    parameter int NUM_REQ = regfile_pkg::NUM_REQ,
    parameter int XLEN    = regfile_pkg::XLEN,
    parameter int AW      = regfile_pkg::AW
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    iss_valid,
    input  logic [AW-1:0]           iss_rs1,
    input  logic [AW-1:0]           iss_rs2,
    input  logic [AW-1:0]           iss_rd,
    input  logic                    iss_has_rd,
    output logic                    iss_stall,
    input  logic [NUM_REQ-1:0]      wb_valid,
    input  logic [NUM_REQ*AW-1:0]   wb_rd,
    input  logic [NUM_REQ*XLEN-1:0] wb_data,
    output logic [NUM_REQ-1:0]      wb_ready,
    output logic                    rf_we,
    output logic [AW-1:0]           rf_rd_addr,
    output logic [XLEN-1:0]         rf_rd_data,
    output logic [(1<<AW)-1:0]      sb_busy,
    output logic                    sb_err
);
    localparam int NR = 1 << AW;

    logic [NUM_REQ-1:0] w_gnt;
    logic               w_xfer;
    logic               w_write;
    logic [AW-1:0]      w_rd;
    logic [XLEN-1:0]    w_data;
    logic               w_issue;
    logic [NR-1:0]      w_busy_nxt;
    logic [NR-1:0]      r_busy;
    logic               r_err;
    logic               r_we_p1;
    logic [AW-1:0]      r_addr_p1;
    logic [XLEN-1:0]    r_data_p1;

    rr_arbiter #(.N(NUM_REQ)) u_arb (
        .clk     (clk),
        .rst     (rst),
        .req     (wb_valid),
        .advance (w_xfer),
        .gnt     (w_gnt)
    );

    assign wb_ready = w_gnt;
    assign w_xfer   = |w_gnt;
    assign w_write  = w_xfer && (w_rd != '0);

    always_comb begin
        w_rd   = '0;
        w_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_gnt[i]) begin
                w_rd   = wb_rd[i*AW +: AW];
                w_data = wb_data[i*XLEN +: XLEN];
            end
        end
    end

    assign iss_stall = iss_valid & (r_busy[iss_rs1] | r_busy[iss_rs2] | (iss_has_rd & r_busy[iss_rd]));
    assign w_issue   = iss_valid & ~iss_stall & iss_has_rd & (iss_rd != '0);

    // Clear on the commit edge, then set; a same-index set therefore wins.
    always_comb begin
        w_busy_nxt = r_busy;
        if (r_we_p1) w_busy_nxt[r_addr_p1] = 1'b0;
        if (w_issue) w_busy_nxt[iss_rd] = 1'b1;
        w_busy_nxt[0] = 1'b0;
    end

    // Write-port stage: the granted payload lands on the register file one cycle later.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_busy    <= '0;
            r_err     <= 1'b0;
            r_we_p1   <= 1'b0;
            r_addr_p1 <= '0;
            r_data_p1 <= '0;
        end else begin
            r_busy  <= w_busy_nxt;
            r_we_p1 <= w_write;
            if (w_write) begin
                r_addr_p1 <= w_rd;
                r_data_p1 <= w_data;
                if (!r_busy[w_rd]) r_err <= 1'b1;
            end
        end
    end

    assign rf_we      = r_we_p1;
    assign rf_rd_addr = r_addr_p1;
    assign rf_rd_data = r_data_p1;
    assign sb_busy    = r_busy;
    assign sb_err     = r_err;
endmodule
